imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction memory: receives a program image as a byte stream and writes it word-by-word into a writable instruction memory. Used at boot or test time to load code before the single-cycle core fetches. Holds the core in reset (core_hold) while loading. Write port addressing matches the fetch side: byte address, word-aligned, word index = address[INS_ADDRESS-1:2].

Parameters:
INS_ADDRESS, 9, byte-address width of instruction memory; depth = 2**(INS_ADDRESS-2) words
INS_W, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  pulse; begins a load session when in IDLE, ignored otherwise
s_valid  input  1  byte stream valid
s_data  input  8  byte stream data
s_ready  output  1  byte accepted on s_valid && s_ready
we  output  1  instruction-memory write enable, one-cycle pulse per word
wa  output  INS_ADDRESS  write byte address, wa[1:0] always 0
wd  output  INS_W  write data
core_hold  output  1  high from start accept until the cycle after done
done  output  1  one-cycle pulse, load completed
err  output  1  sticky length error, cleared by next start or reset

Behaviour:
- Reset values: s_ready=0, we=0, wa=0, wd=0, core_hold=0, done=0, err=0, state=IDLE, all counters 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N instruction bytes, each word little-endian (first byte -> wd[7:0]).
- States: IDLE, LEN0, LEN1, DATA, FLUSH, DONE, ERR.
- IDLE: s_ready=0. start -> LEN0, core_hold<=1, err<=0, word_idx<=0, byte_idx<=0.
- LEN0: s_ready=1; accepted byte -> len[7:0], go LEN1.
- LEN1: s_ready=1; accepted byte -> len[15:8]. Full len==0 -> DONE. len > 2**(INS_ADDRESS-2) -> ERR. Else -> DATA.
- DATA: s_ready=1. Accepted bytes shift into a 24-bit packer; byte_idx wraps 3->0. On 4th byte: wd<={s_data,packer}, wa<={word_idx,2'b00}, we<=1 next cycle (registered, latency 1 cycle from 4th-byte accept to we). word_idx increments on each word. If that word is word N-1 -> FLUSH; else stay DATA and keep accepting (back-to-back words allowed; one write per 4 accepts, no stall).
- FLUSH: s_ready=0; the final we pulse is driven this cycle; -> DONE.
- DONE: done=1 for exactly one cycle, core_hold<=0 on exit, -> IDLE.
- ERR: s_ready=0, err=1, core_hold stays 1 (core must not run a bad image); no writes. Leaves only on start (-> LEN0) or reset.
- s_valid low mid-word: packer and byte_idx hold; no timeout.
- start while not IDLE/ERR: ignored.
- len == depth: legal, last wa = (depth-1)<<2; word_idx must not wrap before compare (counter width INS_ADDRESS-1 bits).
- Reset mid-load: immediate abort, we deasserted asynchronously, partially-assembled word discarded, already-written words remain in memory.
- Bytes presented while s_ready=0 are not consumed.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LEN0, LEN1, DATA, FLUSH, DONE, ERR), LEN_W=16, BYTES_PER_WORD=4.
- One sub-module natural: le_word_packer (byte shift register + 2-bit byte_idx, emits word and word_valid on 4th byte).

Test Plan:
- Load N=3 words 0x00100093, 0x00200113, 0x00308193 (bytes 03 00 93 00 10 00 ...) back-to-back -> three we pulses, wa=0x000,0x004,0x008, wd matches; done pulse, core_hold falls after done.
- Same stream with s_valid toggled every other cycle -> identical writes, no extra we, byte order preserved.
- LEN=0 (00 00) -> no we, done one cycle after LEN_HI accept, core_hold 1 only during session.
- LEN=129 with INS_ADDRESS=9 (depth 128) -> err=1, s_ready=0, no we, core_hold stays 1; next start with LEN=1 clears err and loads wa=0.
- LEN=128 full image -> 128 writes, last wa=0x1FC, no address wrap.
- Reset asserted after 6 data bytes -> outputs to reset values immediately, only word 0 written; fresh start reloads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    function automatic int depth_words(input int ins_address);
        return 1 << (ins_address - 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
);
    logic                   s_valid;
    logic [7:0]             s_data;
    logic                   s_ready;
    logic                   we;
    logic [INS_ADDRESS-1:0] wa;
    logic [INS_W-1:0]       wd;

    modport master (output s_valid, s_data, input s_ready, we, wa, wd);
    modport slave  (input s_valid, s_data, output s_ready, we, wa, wd);
endinterface

// File: rtl/imem_loader_le_word_packer.sv
// Little-endian byte-to-word packer: first byte lands in word[7:0].
module le_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] packer;
    logic [1:0]  byte_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            packer   <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            packer   <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            packer   <= {byte_in, packer[23:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word       = {byte_in, packer};
    assign word_valid = shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the core.
//   state | meaning
//   IDLE  | waiting for start
//   LEN0  | accept word count low byte
//   LEN1  | accept word count high byte, validate
//   DATA  | accept instruction bytes, one write per 4 bytes
//   FLUSH | final write pulse on the bus
//   DONE  | one-cycle done pulse, release core
//   ERR   | bad length; hold core until next start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_hold,
    output logic          done,
    output logic          err
);

    localparam int DEPTH = depth_words(INS_ADDRESS);

    state_t                 state;
    logic                   s_ready_q;
    logic                   we_q;
    logic [INS_ADDRESS-1:0] wa_q;
    logic [INS_W-1:0]       wd_q;
    logic [LEN_W-1:0]       len;
    // one bit wider than the word index so len == DEPTH compares without wrap
    logic [INS_ADDRESS-2:0] word_idx;

    logic                   accept;
    logic [LEN_W-1:0]       len_full;
    logic                   last_word;
    logic                   start_ok;
    logic [31:0]            word;
    logic                   word_valid;

    assign accept    = s_ready_q && bus.s_valid;
    assign len_full  = {bus.s_data, len[7:0]};
    assign last_word = (LEN_W'(word_idx) == (len - LEN_W'(1)));
    assign start_ok  = start && ((state == IDLE) || (state == ERR));

    le_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .shift_en   (accept && (state == DATA)),
        .byte_in    (bus.s_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_ready_q <= 1'b0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= '0;
            word_idx  <= '0;
        end else begin
            we_q <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start_ok) begin
                        state     <= LEN0;
                        s_ready_q <= 1'b1;
                        core_hold <= 1'b1;
                        err       <= 1'b0;
                        word_idx  <= '0;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len[7:0] <= bus.s_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len <= len_full;
                        if (len_full == '0) begin
                            state     <= DONE;
                            s_ready_q <= 1'b0;
                            done      <= 1'b1;
                        end else if ({1'b0, len_full} > (LEN_W+1)'(DEPTH)) begin
                            state     <= ERR;
                            s_ready_q <= 1'b0;
                            err       <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        wd_q     <= word;
                        wa_q     <= {word_idx[INS_ADDRESS-3:0], 2'b00};
                        we_q     <= 1'b1;
                        word_idx <= word_idx + 1'b1;
                        if (last_word) begin
                            state     <= FLUSH;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    core_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.we      = we_q;
    assign bus.wa      = wa_q;
    assign bus.wd      = wd_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load sessions checked against a word-list model of the image.
module tb_imem_loader;

    localparam int INS_ADDRESS = 9;
    localparam int INS_W       = 32;
    localparam int DEPTH       = 1 << (INS_ADDRESS - 2);

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic core_hold, done, err;

    imem_loader_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) bus ();

    imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // observed writes, captured mid-cycle
    logic [INS_ADDRESS-1:0] wr_addr[$];
    logic [INS_W-1:0]       wr_data[$];
    int                     wr_cyc[$];
    // cycle stamp of every fourth data byte accepted, and the model image
    int                     acc_cyc[$];
    logic [31:0]            exp_words[$];

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wr_addr.push_back(bus.wa);
            wr_data.push_back(bus.wd);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_min, input int gap_max);
        bit ok = 0;
        if (gap_max > 0) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            repeat ($urandom_range(gap_max, gap_min)) begin
                @(posedge clk); #1;
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_done(input int exp_delay);
        int k = 0;
        bit seen = 0;
        for (k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", 64'(seen), 1);
        check("done_delay", 64'(k), 64'(exp_delay));
        check("hold_at_done", 64'(core_hold), 1);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 0);
        check("hold_released", 64'(core_hold), 0);
    endtask

    // Full session from start to done/err; expectations come from exp_words and len alone.
    task automatic load(input int len, input int gap_min, input int gap_max);
        clear_obs();
        pulse_start();
        check("hold_on_start", 64'(core_hold), 1);
        check("err_cleared", 64'(err), 0);
        send_byte(8'(len), gap_min, gap_max);
        send_byte(8'(len >> 8), gap_min, gap_max);
        bus.s_valid = 1'b0;
        if (len > DEPTH) begin
            @(negedge clk);
            check("err_set", 64'(err), 1);
            check("err_ready", 64'(bus.s_ready), 0);
            bus.s_valid = 1'b1;
            bus.s_data  = 8'hA5;
            repeat (4) @(negedge clk);
            bus.s_valid = 1'b0;
            check("err_hold", 64'(core_hold), 1);
            check("err_sticky", 64'(err), 1);
            check("err_no_write", 64'(wr_addr.size()), 0);
            check("err_no_done", 64'(done), 0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(exp_words[i][8*b +: 8], gap_min, gap_max);
                if (b == 3) acc_cyc.push_back(cyc);
            end
        end
        bus.s_valid = 1'b0;
        wait_done(len == 0 ? 1 : 2);
        check("write_count", 64'(wr_addr.size()), 64'(len));
        for (int i = 0; i < len && i < wr_addr.size(); i++) begin
            check($sformatf("wa[%0d]", i), 64'(wr_addr[i]), 64'(i * 4));
            check($sformatf("wd[%0d]", i), 64'(wr_data[i]), 64'(exp_words[i]));
            // we is visible in the cycle right after the 4th-byte accept edge
            check($sformatf("we_lat[%0d]", i), 64'(wr_cyc[i]), 64'(acc_cyc[i]));
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #1;
        check("rst_ready", 64'(bus.s_ready), 0);
        check("rst_we", 64'(bus.we), 0);
        check("rst_wa", 64'(bus.wa), 0);
        check("rst_wd", 64'(bus.wd), 0);
        check("rst_hold", 64'(core_hold), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // bytes offered while idle must not be consumed
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h7F;
        repeat (3) @(negedge clk);
        check("idle_ready", 64'(bus.s_ready), 0);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;

        exp_words = '{32'h00100093, 32'h00200113, 32'h00308193};
        load(3, 0, 0);
        load(3, 1, 1);

        load(0, 0, 0);

        load(129, 0, 0);
        load(256, 0, 0);
        exp_words = '{32'hDEADBEEF};
        load(1, 0, 0);

        exp_words.delete();
        for (int i = 0; i < DEPTH; i++) exp_words.push_back($urandom);
        load(DEPTH, 0, 0);
        if (wr_addr.size() == DEPTH) check("last_wa", 64'(wr_addr[DEPTH-1]), 64'h1FC);

        exp_words.delete();
        for (int i = 0; i < 7; i++) exp_words.push_back($urandom);
        load(7, 0, 3);

        // abort mid-load after six data bytes
        exp_words = '{$urandom, $urandom, $urandom};
        clear_obs();
        pulse_start();
        send_byte(8'd3, 0, 0);
        send_byte(8'd0, 0, 0);
        for (int b = 0; b < 6; b++) send_byte(exp_words[b / 4][8*(b % 4) +: 8], 0, 0);
        bus.s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("abort_ready", 64'(bus.s_ready), 0);
        check("abort_we", 64'(bus.we), 0);
        check("abort_wa", 64'(bus.wa), 0);
        check("abort_wd", 64'(bus.wd), 0);
        check("abort_hold", 64'(core_hold), 0);
        check("abort_done", 64'(done), 0);
        check("abort_err", 64'(err), 0);
        check("abort_writes", 64'(wr_addr.size()), 1);
        if (wr_data.size() > 0) check("abort_word0", 64'(wr_data[0]), 64'(exp_words[0]));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        exp_words = '{$urandom, $urandom};
        load(2, 0, 2);

        // async deassert of we: reset lands during a write pulse
        exp_words = '{$urandom};
        clear_obs();
        pulse_start();
        send_byte(8'd1, 0, 0);
        send_byte(8'd0, 0, 0);
        for (int b = 0; b < 4; b++) send_byte(exp_words[0][8*b +: 8], 0, 0);
        bus.s_valid = 1'b0;
        check("flush_we", 64'(bus.we), 1);
        reset = 1'b1;
        #1;
        check("async_we", 64'(bus.we), 0);
        check("async_hold", 64'(core_hold), 0);
        @(posedge clk); #1 reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
